// File: rtl/trig_sample_collector.sv
// rtl/trig_sample_collector.sv - trigger-centred circular sample capture with oldest-first stream dump
// Holds PRE_TRIG samples before the trigger and DEPTH-PRE_TRIG from it on, then replays the window.
module trig_sample_collector #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 128,
  parameter int PRE_TRIG = 16,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_trig,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_pre_ok,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [ADDR_W-1:0] PRE_N     = ADDR_W'(PRE_TRIG);
  localparam logic [ADDR_W-1:0] POST_N    = ADDR_W'(DEPTH - PRE_TRIG);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DUMP} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, pre_cnt, post_cnt;
  logic [ADDR_W-1:0] wr_nxt, rd_nxt, pre_cnt_nxt;
  logic              wr_en, trig_ok, cap_last, beat, last_beat;

  // i_start overrides everything else in the same cycle, so it masks all qualifiers
  always_comb begin
    wr_en     = !i_start && i_valid && (state == ARMED || state == CAPTURE);
    trig_ok   = wr_en && (state == ARMED) && i_trig && o_pre_ok;
    cap_last  = (trig_ok && POST_N == ONE) ||
                (wr_en && state == CAPTURE && post_cnt == POST_N - ONE);
    beat      = !i_start && (state == DUMP) && o_valid && i_ready;
    last_beat = beat && (o_addr == LAST_ADDR);
    wr_nxt    = wr_ptr + ONE;
    rd_nxt    = rd_ptr + ONE;
    pre_cnt_nxt = pre_cnt;
    if (wr_en && state == ARMED && pre_cnt != PRE_N)
      pre_cnt_nxt = pre_cnt + ONE;
  end

  always_comb begin
    state_nxt = state;
    if (i_start) begin
      state_nxt = ARMED;
    end else begin
      case (state)
        ARMED:   if (trig_ok) state_nxt = cap_last ? DUMP : CAPTURE;
        CAPTURE: if (cap_last) state_nxt = DUMP;
        DUMP:    if (last_beat) state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  assign o_busy = (state != IDLE);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= i_data;
    end
  end

  // The slot after the final write is the oldest sample: trigger address minus PRE_TRIG
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pre_cnt  <= '0;
      post_cnt <= '0;
      o_data   <= '0;
      o_valid  <= 1'b0;
      o_addr   <= '0;
      o_pre_ok <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (i_start) begin
        wr_ptr   <= '0;
        pre_cnt  <= '0;
        post_cnt <= '0;
        o_valid  <= 1'b0;
        o_addr   <= '0;
        o_pre_ok <= 1'b0;
      end else begin
        if (wr_en) wr_ptr <= wr_nxt;
        pre_cnt <= pre_cnt_nxt;
        if (trig_ok)
          post_cnt <= ONE;
        else if (wr_en && state == CAPTURE)
          post_cnt <= post_cnt + ONE;
        o_pre_ok <= (state_nxt == ARMED || state_nxt == CAPTURE) && (pre_cnt_nxt == PRE_N);
        if (cap_last) begin
          rd_ptr  <= wr_nxt;
          o_data  <= mem[wr_nxt];
          o_valid <= 1'b1;
          o_addr  <= '0;
        end else if (beat) begin
          if (last_beat) begin
            o_valid <= 1'b0;
            o_done  <= 1'b1;
          end else begin
            rd_ptr <= rd_nxt;
            o_addr <= o_addr + ONE;
            o_data <= mem[rd_nxt];
          end
        end
      end
    end
  end

endmodule
